// File: rtl/simon_data_out_if.sv
// Purpose: bundles the core-side block handshake and host-side packet handshake of simon_data_out.
// Ports:   master = producer/sender view (drives newBlock, blockOUT, infoIN, loadPkt);
//          slave  = packetiser view (drives loadBlock, newPkt, out, errPkt).
interface simon_data_out_if #(
    parameter int N = 16
);
    logic                  newBlock;
    logic [1:0][N-1:0]     blockOUT;
    logic [7:0]            infoIN;
    logic                  loadBlock;
    logic                  loadPkt;
    logic                  newPkt;
    logic [N/2+1:0][7:0]   out;
    logic                  errPkt;

    modport master (
        output newBlock, blockOUT, infoIN, loadPkt,
        input  loadBlock, newPkt, out, errPkt
    );

    modport slave (
        input  newBlock, blockOUT, infoIN, loadPkt,
        output loadBlock, newPkt, out, errPkt
    );
endinterface

// File: rtl/simon_data_out.sv
// Purpose: packs one (single) or two (paired) cipher result blocks into an output packet
//          laid out as 4 data words, count byte, info byte; errPkt flags dropped key blocks.
// Latency/backpressure: block captured at edge t -> loadBlock and (if packet complete) newPkt
//          high after edge t; one packet buffered, blocks are not acked while newPkt is high.
// Ports:   clk, R (sync active-high reset), bus (slave modport of simon_data_out_if).
module simon_data_out #(
    parameter int N    = 16,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           R,
    simon_data_out_if.slave bus
);

    localparam logic [3:0] MODE_C = MODE[3:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e              state_q;
    logic [3:0][N-1:0]   words_q;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_byte_q;
    logic [7:0]          info_byte_q;
    logic                load_block_q;
    logic                new_pkt_q;
    logic                err_pkt_q;

    logic                capture_d;
    logic                is_key_d;
    logic [7:0]          info_byte_d;
    logic                unused_info;

    // The loadBlock_q guard stops a second capture of the same block during
    // the cycle in which the producer is still dropping newBlock.
    assign capture_d   = bus.newBlock && !load_block_q && (state_q != SEND);
    assign is_key_d    = bus.infoIN[5];
    assign info_byte_d = {bus.infoIN[7:5], 1'b1, MODE_C};
    assign unused_info = ^bus.infoIN[4:0];

    always_ff @(posedge clk) begin
        if (R) begin
            state_q      <= IDLE;
            words_q      <= '0;
            cnt_q        <= '0;
            cnt_byte_q   <= '0;
            info_byte_q  <= '0;
            load_block_q <= 1'b0;
            new_pkt_q    <= 1'b0;
            err_pkt_q    <= 1'b0;
        end else begin
            // Every capture is acked, including dropped key blocks.
            load_block_q <= capture_d;
            err_pkt_q    <= capture_d && is_key_d;

            case (state_q)
                IDLE: begin
                    if (capture_d && !is_key_d) begin
                        info_byte_q <= info_byte_d;
                        if (bus.infoIN[7]) begin
                            words_q[0] <= bus.blockOUT[0];
                            words_q[1] <= bus.blockOUT[1];
                            state_q    <= HALF;
                        end else begin
                            words_q[0] <= '0;
                            words_q[1] <= '0;
                            words_q[2] <= bus.blockOUT[0];
                            words_q[3] <= bus.blockOUT[1];
                            cnt_byte_q <= cnt_q;
                            new_pkt_q  <= 1'b1;
                            state_q    <= SEND;
                        end
                    end
                end
                HALF: begin
                    // Second block's info byte is ignored; the first block's is kept.
                    if (capture_d && !is_key_d) begin
                        words_q[2] <= bus.blockOUT[0];
                        words_q[3] <= bus.blockOUT[1];
                        cnt_byte_q <= cnt_q;
                        new_pkt_q  <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (bus.loadPkt) begin
                        new_pkt_q <= 1'b0;
                        cnt_q     <= cnt_q + 8'd1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.loadBlock = load_block_q;
    assign bus.newPkt    = new_pkt_q;
    assign bus.errPkt    = err_pkt_q;
    // Byte order low to high: word0..word3 (little-endian), count, info.
    assign bus.out       = {info_byte_q, cnt_byte_q, words_q};

endmodule

// File: tb/tb_simon_data_out.sv
module tb_simon_data_out;

    localparam int N  = 16;
    localparam int PW = (N/2 + 2) * 8;

    logic clk = 1'b0;
    logic R   = 1'b1;
    always #5 clk = ~clk;

    simon_data_out_if #(.N(N)) bus ();

    simon_data_out #(.N(N), .MODE(0)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    typedef struct {
        logic [15:0]   b0;
        logic [15:0]   b1;
        logic [7:0]    info;
        logic          key;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t          vecs[7];
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_exp;
    logic [7:0]    exp_cnt;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                         input logic [15:0] w2, input logic [15:0] w3,
                                         input logic [7:0] c, input logic [2:0] hi);
        return {hi, 1'b1, 4'h0, c, w3, w2, w1, w0};
    endfunction

    // Present one block, wait for its ack, then drop newBlock.
    task automatic drive_block(input string nm, input logic [15:0] b0, input logic [15:0] b1,
                               input logic [7:0] info, output logic err_seen);
        int t;
        bus.newBlock    = 1'b1;
        bus.blockOUT[0] = b0;
        bus.blockOUT[1] = b1;
        bus.infoIN      = info;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.loadBlock && t < 20);
        chk({nm, " loadBlock seen"}, PW'(bus.loadBlock), PW'(1));
        err_seen     = bus.errPkt;
        bus.newBlock = 1'b0;
        @(negedge clk);
        chk({nm, " loadBlock one cycle"}, PW'(bus.loadBlock), PW'(0));
        chk({nm, " errPkt one cycle"}, PW'(bus.errPkt), PW'(0));
    endtask

    // Wait for a packet, compare it with the oldest expectation, then ack it.
    task automatic recv(input string nm);
        int t = 0;
        while (!bus.newPkt && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " newPkt seen"}, PW'(bus.newPkt), PW'(1));
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: packet with no expectation queued", nm);
        end else begin
            last_exp = exp_q.pop_front();
            chk({nm, " out"}, bus.out, last_exp);
        end
        bus.loadPkt = 1'b1;
        @(negedge clk);
        bus.loadPkt = 1'b0;
        chk({nm, " newPkt falls"}, PW'(bus.newPkt), PW'(0));
        exp_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        err;
        logic [15:0] a0, a1;
        logic [7:0]  inf;

        vecs[0] = '{16'h1234, 16'hBEEF, 8'h00, 1'b0, 80'h1000_BEEF_1234_0000_0000};
        vecs[1] = '{16'hA5A5, 16'h5A5A, 8'h40, 1'b0, 80'h5001_5A5A_A5A5_0000_0000};
        vecs[2] = '{16'hFFFF, 16'h0001, 8'h20, 1'b1, 80'h0};
        vecs[3] = '{16'h0F0F, 16'hF0F0, 8'h60, 1'b1, 80'h0};
        vecs[4] = '{16'h8001, 16'h7FFE, 8'h00, 1'b0, 80'h1002_7FFE_8001_0000_0000};
        vecs[5] = '{16'h00FF, 16'hFF00, 8'h1F, 1'b0, 80'h1003_FF00_00FF_0000_0000};
        vecs[6] = '{16'h5555, 16'hAAAA, 8'hA0, 1'b1, 80'h0};

        bus.newBlock = 1'b0;
        bus.blockOUT = '0;
        bus.infoIN   = '0;
        bus.loadPkt  = 1'b0;
        exp_cnt      = 8'h00;
        last_exp     = '0;

        repeat (3) @(negedge clk);
        R = 1'b0;
        chk("reset loadBlock", PW'(bus.loadBlock), PW'(0));
        chk("reset newPkt", PW'(bus.newPkt), PW'(0));
        chk("reset errPkt", PW'(bus.errPkt), PW'(0));
        chk("reset out", bus.out, '0);

        // Stray ack with no packet must not advance the counter.
        bus.loadPkt = 1'b1;
        @(negedge clk);
        bus.loadPkt = 1'b0;
        chk("stray loadPkt newPkt", PW'(bus.newPkt), PW'(0));

        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].key) exp_q.push_back(vecs[i].exp);
            drive_block($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].info, err);
            chk($sformatf("vec%0d errPkt", i), PW'(err), PW'(vecs[i].key));
            if (!vecs[i].key) begin
                recv($sformatf("vec%0d", i));
            end else begin
                repeat (3) begin
                    chk($sformatf("vec%0d key newPkt", i), PW'(bus.newPkt), PW'(0));
                    @(negedge clk);
                end
                chk($sformatf("vec%0d key out kept", i), bus.out, last_exp);
            end
        end

        // Paired packet: info from block A, no packet until block B.
        drive_block("pairA", 16'h1111, 16'h2222, 8'h80, err);
        chk("pairA errPkt", PW'(err), PW'(0));
        repeat (3) begin
            chk("pairA newPkt low", PW'(bus.newPkt), PW'(0));
            @(negedge clk);
        end
        exp_q.push_back(mk(16'h1111, 16'h2222, 16'h3333, 16'h4444, exp_cnt, 3'b100));
        drive_block("pairB", 16'h3333, 16'h4444, 8'h00, err);
        recv("pair");

        // Key block arriving in HALF is dropped; the pair still completes.
        drive_block("hkA", 16'h0101, 16'h0202, 8'hC0, err);
        drive_block("hkKey", 16'hDEAD, 16'hDEAD, 8'h20, err);
        chk("half key errPkt", PW'(err), PW'(1));
        chk("half key newPkt", PW'(bus.newPkt), PW'(0));
        exp_q.push_back(mk(16'h0101, 16'h0202, 16'h0303, 16'h0404, exp_cnt, 3'b110));
        drive_block("hkB", 16'h0303, 16'h0404, 8'h80, err);
        recv("half key pair");

        // Backpressure: second block waits unacked while the first packet is held.
        exp_q.push_back(mk(16'h0, 16'h0, 16'hAAAA, 16'hBBBB, exp_cnt, 3'b000));
        drive_block("bp1", 16'hAAAA, 16'hBBBB, 8'h00, err);
        bus.newBlock    = 1'b1;
        bus.blockOUT[0] = 16'hCCCC;
        bus.blockOUT[1] = 16'hDDDD;
        bus.infoIN      = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp hold loadBlock c%0d", c), PW'(bus.loadBlock), PW'(0));
            chk($sformatf("bp hold out c%0d", c), bus.out, exp_q[0]);
        end
        last_exp = exp_q.pop_front();
        chk("bp newPkt held", PW'(bus.newPkt), PW'(1));
        bus.loadPkt = 1'b1;
        @(negedge clk);
        bus.loadPkt = 1'b0;
        exp_cnt++;
        chk("bp newPkt falls", PW'(bus.newPkt), PW'(0));
        chk("bp no capture in ack cycle", PW'(bus.loadBlock), PW'(0));
        @(negedge clk);
        chk("bp second captured", PW'(bus.loadBlock), PW'(1));
        bus.newBlock = 1'b0;
        exp_q.push_back(mk(16'h0, 16'h0, 16'hCCCC, 16'hDDDD, exp_cnt, 3'b000));
        recv("bp second");

        // Reset in the middle of a pair discards the half-built packet.
        drive_block("rstA", 16'h7777, 16'h8888, 8'h80, err);
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
        exp_cnt = 8'h00;
        chk("mid reset newPkt", PW'(bus.newPkt), PW'(0));
        chk("mid reset out", bus.out, '0);
        chk("mid reset loadBlock", PW'(bus.loadBlock), PW'(0));
        exp_q.push_back(mk(16'h0, 16'h0, 16'hCAFE, 16'hF00D, 8'h00, 3'b000));
        drive_block("post reset", 16'hCAFE, 16'hF00D, 8'h00, err);
        recv("post reset");

        // Counter wrap: 256 more singles take the count byte 01..FF then 00.
        for (int i = 0; i < 256; i++) begin
            a0  = 16'($urandom);
            a1  = 16'($urandom);
            inf = {1'b0, 1'($urandom), 1'b0, 5'($urandom)};
            exp_q.push_back(mk(16'h0, 16'h0, a0, a1, exp_cnt, inf[7:5]));
            drive_block($sformatf("wrap%0d", i), a0, a1, inf, err);
            recv($sformatf("wrap%0d", i));
        end
        chk("wrap final count byte", PW'(last_exp[71:64]), PW'(8'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
